b_resp_order_tracker: RTL and testbench
=======================================

B_RESP_ORDER_TRACKER -- requirements
Module: b_resp_order_tracker

Interface
REQ-001 SHALL have parameter N_ID, default 4, meaning number of tracked write IDs (1..16).
REQ-002 SHALL have parameter ID_WIDTH, default 2, meaning ID field width, with 2^ID_WIDTH >= N_ID.
REQ-003 SHALL have parameter SEQ_WIDTH, default 4, meaning sequence tag width.
REQ-004 SHALL have parameter MAX_OUT, default 15, meaning per-ID outstanding limit, 1..2^SEQ_WIDTH-1.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, meaning reset, synchronous, active-high.
REQ-007 SHALL have port issue_valid, input, 1, meaning a write address is being issued.
REQ-008 SHALL have port issue_id, input, ID_WIDTH, meaning the ID of the issued write.
REQ-009 SHALL have port issue_ready, output, 1, meaning issue_id has room for another outstanding write.
REQ-010 SHALL have port issue_seq, output, SEQ_WIDTH, meaning the sequence tag assigned to the current issue.
REQ-011 SHALL have port BID, input, ID_WIDTH+SEQ_WIDTH, meaning the response tag: {seq, id}, with id in the low bits.
REQ-012 SHALL have port BVALID, input, 1, meaning a response is present.
REQ-013 SHALL have port BREADY, input, 1, meaning the response is accepted this cycle.
REQ-014 SHALL have port b_match, output, 1, meaning the presented response is the next expected one for its ID.
REQ-015 SHALL have port err_order, output, 1, meaning a registered one-cycle pulse for an accepted response that is out of order or unexpected.
REQ-016 SHALL have port err_id, output, 1, meaning a registered one-cycle pulse for an accepted response whose id >= N_ID.
REQ-017 SHALL have port busy, output, 1, meaning at least one ID has outstanding writes.

Function
REQ-018 Per ID i, two SEQ_WIDTH counters SHALL be kept: iss_cnt[i] and ret_cnt[i]. Outstanding out[i] SHALL equal (iss_cnt[i] - ret_cnt[i]) mod 2^SEQ_WIDTH.
REQ-019 issue_seq SHALL equal iss_cnt[issue_id], combinationally. For issue_id >= N_ID it SHALL be 0.
REQ-020 issue_ready SHALL be high iff issue_id < N_ID and out[issue_id] < MAX_OUT.
REQ-021 On issue_valid && issue_ready, iss_cnt[issue_id] SHALL increment by 1 at the next edge. It SHALL wrap modulo 2^SEQ_WIDTH.
REQ-022 An issue with issue_ready low SHALL be ignored, with no state change.
REQ-023 b_match SHALL be combinational and high iff all of the following hold: BVALID; id < N_ID; out[id] > 0; BID seq field == ret_cnt[id].
REQ-024 On BVALID && BREADY && b_match, ret_cnt[id] SHALL increment by 1 at the next edge, with wrap.
REQ-025 On BVALID && BREADY && id < N_ID && !b_match, err_order SHALL pulse high for exactly the following cycle. No counter SHALL change.
REQ-026 On BVALID && BREADY && id >= N_ID, err_id SHALL pulse high for exactly the following cycle. err_order SHALL stay low.
REQ-027 A simultaneous issue and retire on the same ID SHALL update both counters in the same edge, leaving out[id] unchanged.
REQ-028 A simultaneous issue and retire on different IDs SHALL be handled independently.
REQ-029 busy SHALL be the registered OR of (out[i] != 0) over all i, with one-cycle latency.
REQ-030 BVALID without BREADY SHALL never change state.

Reset
REQ-031 When reset is high at a clock edge, all counters SHALL be cleared to 0, and err_order, err_id and busy SHALL be cleared to 0.
REQ-032 Reset SHALL override any concurrent issue or retire.
REQ-033 Reset during outstanding traffic SHALL discard all tracking. The first post-reset response for an ID SHALL then be reported as err_order, since out = 0.

Structure
REQ-034 A shared package axi_bseq_pkg SHALL hold the default constants (N_ID, ID_WIDTH, SEQ_WIDTH, MAX_OUT) and an id/seq field-extract typedef.
REQ-035 The per-ID counter pair, with its compare and increment logic, SHALL be one sub-module, b_id_seq_slice, instantiated N_ID times by a generate loop.
REQ-036 The top level SHALL contain only the ID decode/mux, error registers and busy reduction.

Verification
REQ-037 Scenario in-order: issue ID1 three times (seq 0,1,2), then return BID {0,1},{1,1},{2,1} with BREADY=1. Required: b_match=1 each time; no errors; busy drops one cycle after the last retire.
REQ-038 Scenario out-of-order: issue ID2 twice, then return {1,2} first. Required: b_match=0 and err_order pulse; ret_cnt[2] stays 0. A following {0,2} SHALL match.
REQ-039 Scenario full/wrap: issue 15 writes on ID0. Required: issue_ready=0 at out=15. Retire one, then issue one. Required: issue_seq=15, then 0 after wrap; b_match tracks across the wrap.
REQ-040 Scenario simultaneous: with out[3]=1, issue ID3 and retire the matching {0,3} in the same cycle. Required: out[3] stays 1, issue_seq was 1, busy stays 1.
REQ-041 Scenario bad ID (N_ID=3): BID id=3 with BVALID and BREADY. Required: err_id pulse, err_order=0, no counter change.
REQ-042 Scenario reset mid-traffic: assert reset with 5 outstanding on ID0. Required: next cycle busy=0 and issue_seq=0; then response {5,0} gives err_order.

Source files
------------

// File: rtl/axi_bseq_pkg.sv
// Shared defaults and field layout for write-response order tracking.
package axi_bseq_pkg;

    localparam int DEF_N_ID      = 4;
    localparam int DEF_ID_WIDTH  = 2;
    localparam int DEF_SEQ_WIDTH = 4;
    localparam int DEF_MAX_OUT   = 15;

    // Response tag layout at the default widths: sequence tag above, ID in the low bits.
    typedef struct packed {
        logic [DEF_SEQ_WIDTH-1:0] seq;
        logic [DEF_ID_WIDTH-1:0]  id;
    } bid_t;

endpackage

// File: rtl/b_resp_order_tracker_if.sv
// Issue channel and write-response channel seen by the order tracker.
interface b_resp_order_tracker_if #(
    parameter int ID_WIDTH  = 2,
    parameter int SEQ_WIDTH = 4
);
    logic                          issue_valid;
    logic [ID_WIDTH-1:0]           issue_id;
    logic                          issue_ready;
    logic [SEQ_WIDTH-1:0]          issue_seq;
    logic [ID_WIDTH+SEQ_WIDTH-1:0] BID;
    logic                          BVALID;
    logic                          BREADY;
    logic                          b_match;

    // Traffic source: issues writes and presents responses.
    modport master (
        output issue_valid, issue_id, BID, BVALID, BREADY,
        input  issue_ready, issue_seq, b_match
    );

    // Tracker side.
    modport slave (
        input  issue_valid, issue_id, BID, BVALID, BREADY,
        output issue_ready, issue_seq, b_match
    );
endinterface

// File: rtl/b_id_seq_slice.sv
// One write ID: issued/returned counter pair, room check and in-order compare.
module b_id_seq_slice #(
    parameter int SEQ_WIDTH = 4,
    parameter int MAX_OUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_en,
    input  logic                 retire_en,
    input  logic [SEQ_WIDTH-1:0] rsp_seq,
    output logic [SEQ_WIDTH-1:0] iss_seq,
    output logic                 can_issue,
    output logic                 seq_match,
    output logic                 out_nz
);
    localparam logic [SEQ_WIDTH-1:0] SEQ_ZERO  = {SEQ_WIDTH{1'b0}};
    localparam logic [SEQ_WIDTH-1:0] SEQ_ONE   = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SEQ_WIDTH-1:0] MAX_OUT_W = SEQ_WIDTH'(MAX_OUT);

    logic [SEQ_WIDTH-1:0] iss_cnt_q, iss_cnt_d;
    logic [SEQ_WIDTH-1:0] ret_cnt_q, ret_cnt_d;
    logic [SEQ_WIDTH-1:0] out_s;

    // Outstanding count is the modular distance between the two counters.
    always_comb begin
        out_s     = iss_cnt_q - ret_cnt_q;
        out_nz    = (out_s != SEQ_ZERO);
        can_issue = (out_s < MAX_OUT_W);
        seq_match = out_nz && (rsp_seq == ret_cnt_q);
        iss_seq   = iss_cnt_q;
    end

    // Counter advance; both may step on the same edge, wrapping naturally.
    always_comb begin
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (issue_en) begin
            iss_cnt_d = iss_cnt_q + SEQ_ONE;
        end else begin
            iss_cnt_d = iss_cnt_q;
        end
        if (retire_en) begin
            ret_cnt_d = ret_cnt_q + SEQ_ONE;
        end else begin
            ret_cnt_d = ret_cnt_q;
        end
    end

    // Counter registers; reset discards all tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_cnt_q <= SEQ_ZERO;
            ret_cnt_q <= SEQ_ZERO;
        end else begin
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end
endmodule

// File: rtl/b_resp_order_tracker.sv
// Per-ID write-response order tracker: ID decode/mux, error pulses and busy flag.
module b_resp_order_tracker
    import axi_bseq_pkg::*;
#(
    parameter int N_ID      = DEF_N_ID,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int SEQ_WIDTH = DEF_SEQ_WIDTH,
    parameter int MAX_OUT   = DEF_MAX_OUT
) (
    input  logic                   clk,
    input  logic                   reset,
    b_resp_order_tracker_if.slave  bus,
    output logic                   err_order,
    output logic                   err_id,
    output logic                   busy
);
    localparam logic [ID_WIDTH:0] N_ID_W = (ID_WIDTH+1)'(N_ID);

    logic [ID_WIDTH-1:0]  bid_id_s;
    logic [SEQ_WIDTH-1:0] bid_seq_s;
    logic                 bid_id_ok_s;

    logic [SEQ_WIDTH-1:0] iss_seq_s [N_ID];
    logic [N_ID-1:0]      can_issue_s, seq_match_s, out_nz_s;
    logic [N_ID-1:0]      issue_hit_s, bid_hit_s, issue_en_s, retire_en_s;

    logic [SEQ_WIDTH-1:0] issue_seq_s;
    logic                 issue_ready_s, b_match_s;

    logic err_order_q, err_order_d;
    logic err_id_q, err_id_d;
    logic busy_q, busy_d;

    assign bid_id_s    = bus.BID[ID_WIDTH-1:0];
    assign bid_seq_s   = bus.BID[ID_WIDTH+SEQ_WIDTH-1:ID_WIDTH];
    assign bid_id_ok_s = ({1'b0, bid_id_s} < N_ID_W);

    // ID decode, AND-OR mux of the selected slice, and per-slice step enables.
    always_comb begin
        issue_hit_s   = {N_ID{1'b0}};
        bid_hit_s     = {N_ID{1'b0}};
        issue_en_s    = {N_ID{1'b0}};
        retire_en_s   = {N_ID{1'b0}};
        issue_seq_s   = {SEQ_WIDTH{1'b0}};
        issue_ready_s = 1'b0;
        b_match_s     = 1'b0;
        for (int i = 0; i < N_ID; i++) begin
            issue_hit_s[i] = (bus.issue_id == ID_WIDTH'(i));
            bid_hit_s[i]   = (bid_id_s == ID_WIDTH'(i));
            issue_seq_s    = issue_seq_s | (iss_seq_s[i] & {SEQ_WIDTH{issue_hit_s[i]}});
            issue_ready_s  = issue_ready_s | (issue_hit_s[i] & can_issue_s[i]);
            b_match_s      = b_match_s | (bid_hit_s[i] & seq_match_s[i]);
        end
        b_match_s = b_match_s & bus.BVALID;
        for (int i = 0; i < N_ID; i++) begin
            issue_en_s[i]  = bus.issue_valid & issue_ready_s & issue_hit_s[i];
            retire_en_s[i] = bus.BVALID & bus.BREADY & b_match_s & bid_hit_s[i];
        end
    end

    for (genvar g = 0; g < N_ID; g++) begin : g_slice
        b_id_seq_slice #(
            .SEQ_WIDTH (SEQ_WIDTH),
            .MAX_OUT   (MAX_OUT)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .issue_en  (issue_en_s[g]),
            .retire_en (retire_en_s[g]),
            .rsp_seq   (bid_seq_s),
            .iss_seq   (iss_seq_s[g]),
            .can_issue (can_issue_s[g]),
            .seq_match (seq_match_s[g]),
            .out_nz    (out_nz_s[g])
        );
    end

    // Error classification of accepted responses and busy reduction.
    always_comb begin
        err_order_d = bus.BVALID & bus.BREADY & bid_id_ok_s & ~b_match_s;
        err_id_d    = bus.BVALID & bus.BREADY & ~bid_id_ok_s;
        busy_d      = |out_nz_s;
    end

    // Status registers: one-cycle error pulses and lagging busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_order_q <= 1'b0;
            err_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            err_order_q <= err_order_d;
            err_id_q    <= err_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.issue_ready = issue_ready_s;
    assign bus.issue_seq   = issue_seq_s;
    assign bus.b_match     = b_match_s;
    assign err_order       = err_order_q;
    assign err_id          = err_id_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_b_resp_order_tracker.sv
// Directed bench for b_resp_order_tracker: vector table plus multi-cycle sequences.
module tb_b_resp_order_tracker;
    import axi_bseq_pkg::*;

    logic clk;
    logic reset;
    logic err_order, err_id, busy;
    logic err3_order, err3_id, busy3;
    int   errors = 0;
    int   checks = 0;

    b_resp_order_tracker_if #(.ID_WIDTH(2), .SEQ_WIDTH(4)) bus  ();
    b_resp_order_tracker_if #(.ID_WIDTH(2), .SEQ_WIDTH(4)) bus3 ();

    b_resp_order_tracker #(.N_ID(4), .ID_WIDTH(2), .SEQ_WIDTH(4), .MAX_OUT(15)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .err_order(err_order), .err_id(err_id), .busy(busy)
    );

    b_resp_order_tracker #(.N_ID(3), .ID_WIDTH(2), .SEQ_WIDTH(4), .MAX_OUT(15)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .err_order(err3_order), .err_id(err3_id), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;  logic [1:0] iid;
        logic       bv;  logic       br;  logic [3:0] bs;  logic [1:0] bi;
        logic       rdy; logic [3:0] seq; logic       match;
        logic       eo;  logic       ei;  logic       busy;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mkv(input logic iv, input logic [1:0] iid, input logic bv,
                                 input logic br, input logic [3:0] bs, input logic [1:0] bi,
                                 input logic rdy, input logic [3:0] seq, input logic match,
                                 input logic eo, input logic ei, input logic bz);
        vec_t v;
        v.iv = iv; v.iid = iid; v.bv = bv; v.br = br; v.bs = bs; v.bi = bi;
        v.rdy = rdy; v.seq = seq; v.match = match; v.eo = eo; v.ei = ei; v.busy = bz;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] iid, input logic bv,
                         input logic br, input logic [3:0] bs, input logic [1:0] bi);
        bid_t b;
        b.seq = bs;
        b.id  = bi;
        bus.issue_valid = iv;
        bus.issue_id    = iid;
        bus.BVALID      = bv;
        bus.BREADY      = br;
        bus.BID         = b;
    endtask

    task automatic drive3(input logic iv, input logic [1:0] iid, input logic bv,
                          input logic br, input logic [3:0] bs, input logic [1:0] bi);
        bid_t b;
        b.seq = bs;
        b.id  = bi;
        bus3.issue_valid = iv;
        bus3.issue_id    = iid;
        bus3.BVALID      = bv;
        bus3.BREADY      = br;
        bus3.BID         = b;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        // In-order on ID1, out-of-order on ID2, simultaneous issue/retire on ID3.
        vecs[0]  = mkv(1'b1, 2'd1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkv(1'b1, 2'd1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mkv(1'b1, 2'd1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mkv(1'b0, 2'd1, 1'b1, 1'b1, 4'd0, 2'd1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mkv(1'b0, 2'd1, 1'b1, 1'b1, 4'd1, 2'd1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mkv(1'b0, 2'd1, 1'b1, 1'b1, 4'd2, 2'd1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mkv(1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mkv(1'b1, 2'd2, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mkv(1'b1, 2'd2, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mkv(1'b0, 2'd2, 1'b1, 1'b1, 4'd1, 2'd2, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[10] = mkv(1'b0, 2'd2, 1'b1, 1'b1, 4'd0, 2'd2, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[11] = mkv(1'b0, 2'd2, 1'b1, 1'b1, 4'd1, 2'd2, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[12] = mkv(1'b0, 2'd3, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mkv(1'b1, 2'd3, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mkv(1'b1, 2'd3, 1'b1, 1'b1, 4'd0, 2'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[15] = mkv(1'b0, 2'd3, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[16] = mkv(1'b0, 2'd3, 1'b1, 1'b0, 4'd1, 2'd3, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[17] = mkv(1'b0, 2'd3, 1'b1, 1'b1, 4'd1, 2'd3, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[18] = mkv(1'b0, 2'd3, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[19] = mkv(1'b0, 2'd0, 1'b1, 1'b1, 4'd2, 2'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        drive3(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err_order", err_order, 1'b0);
        chk1("rst_err_id", err_id, 1'b0);
        chk4("rst_issue_seq", bus.issue_seq, 4'd0);
        chk1("rst_issue_ready", bus.issue_ready, 1'b1);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].iid, vecs[i].bv, vecs[i].br, vecs[i].bs, vecs[i].bi);
            #2;
            chk1($sformatf("v%0d_issue_ready", i), bus.issue_ready, vecs[i].rdy);
            chk4($sformatf("v%0d_issue_seq", i), bus.issue_seq, vecs[i].seq);
            chk1($sformatf("v%0d_b_match", i), bus.b_match, vecs[i].match);
            @(posedge clk);
            #1;
            chk1($sformatf("v%0d_err_order", i), err_order, vecs[i].eo);
            chk1($sformatf("v%0d_err_id", i), err_id, vecs[i].ei);
            chk1($sformatf("v%0d_busy", i), busy, vecs[i].busy);
        end

        // Fill ID0 to the limit, blocked issue, then retire/issue across the wrap.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
            #2;
            chk4($sformatf("fill%0d_seq", k), bus.issue_seq, 4'(k));
            chk1($sformatf("fill%0d_ready", k), bus.issue_ready, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        #2;
        chk1("full_ready", bus.issue_ready, 1'b0);
        chk4("full_seq", bus.issue_seq, 4'd15);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 4'd0, 2'd0);
        #2;
        chk4("blocked_issue_seq", bus.issue_seq, 4'd15);
        chk1("full_retire_match", bus.b_match, 1'b1);
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        #2;
        chk1("refill_ready", bus.issue_ready, 1'b1);
        chk4("refill_seq", bus.issue_seq, 4'd15);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        #2;
        chk4("wrap_seq", bus.issue_seq, 4'd0);
        chk1("wrap_full_ready", bus.issue_ready, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 1'b1, 1'b1, 4'(k), 2'd0);
            #2;
            chk1($sformatf("drain%0d_match", k), bus.b_match, 1'b1);
            @(posedge clk);
            #1;
            chk1($sformatf("drain%0d_err_order", k), err_order, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 4'd0, 2'd0);
        #2;
        chk1("drained_no_match", bus.b_match, 1'b0);
        chk1("drained_ready", bus.issue_ready, 1'b1);

        // Reset with five outstanding on ID0, concurrent issue and retire ignored.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        #2;
        chk1("pre_reset_busy", busy, 1'b1);
        chk4("pre_reset_seq", bus.issue_seq, 4'd5);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 2'd0, 1'b1, 1'b1, 4'd0, 2'd0);
        @(posedge clk);
        #1;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_err_order", err_order, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        #2;
        chk4("post_reset_seq", bus.issue_seq, 4'd0);
        chk1("post_reset_ready", bus.issue_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 4'd5, 2'd0);
        #2;
        chk1("post_reset_match", bus.b_match, 1'b0);
        @(posedge clk);
        #1;
        chk1("post_reset_err_order", err_order, 1'b1);
        chk1("post_reset_err_id", err_id, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        @(posedge clk);
        #1;
        chk1("err_order_pulse_end", err_order, 1'b0);

        // Out-of-range ID on the three-ID instance.
        @(negedge clk);
        drive3(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);
        #2;
        chk4("n3_issue_seq0", bus3.issue_seq, 4'd0);
        chk1("n3_issue_ready0", bus3.issue_ready, 1'b1);
        @(negedge clk);
        drive3(1'b1, 2'd3, 1'b1, 1'b1, 4'd0, 2'd3);
        #2;
        chk1("n3_bad_match", bus3.b_match, 1'b0);
        chk1("n3_bad_issue_ready", bus3.issue_ready, 1'b0);
        chk4("n3_bad_issue_seq", bus3.issue_seq, 4'd0);
        @(posedge clk);
        #1;
        chk1("n3_err_id", err3_id, 1'b1);
        chk1("n3_err_order", err3_order, 1'b0);
        @(negedge clk);
        drive3(1'b0, 2'd0, 1'b1, 1'b1, 4'd0, 2'd0);
        #2;
        chk1("n3_id0_match", bus3.b_match, 1'b1);
        chk4("n3_id0_seq", bus3.issue_seq, 4'd1);
        @(posedge clk);
        #1;
        chk1("n3_err_id_end", err3_id, 1'b0);
        chk1("n3_err_order_ok", err3_order, 1'b0);
        @(negedge clk);
        drive3(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
